time_set_control: RTL
=====================

Name: time_set_control

Overview:
- Front-end "writer" of the clock datapath, feeding the display path and the timekeeping counters.
- Turns debounced push-buttons into the page select (`mode_time`) and the field select (`select_item`); the display path consumes both.
- Holds shadow copies of the time/date fields while the user edits them.
- Commits edits to the timekeeping counters with a one-cycle load strobe.

Parameters:
- `EDIT_TIMEOUT`, default 500_000_000: idle cycles in EDIT before the edit is aborted.
- `HOLD_CYCLES`, default 25_000_000: press-and-hold delay before auto-repeat starts (`AUTO_REPEAT_EN` only).
- `REPEAT_CYCLES`, default 5_000_000: auto-repeat period (`AUTO_REPEAT_EN` only).

Ports:
- `clk`, input, 1: system clock.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `btn_mode`, input, 1: debounced level, active-high; toggles the page.
- `btn_select`, input, 1: debounced level; enters edit and advances the field.
- `btn_up`, input, 1: debounced level; increments the selected field.
- `btn_down`, input, 1: debounced level; decrements the selected field.
- `second_in`, `minute_in`, `hour_in`, `day_in`, inputs, 6 each: live counter values.
- `month_in`, input, 4: live counter value.
- `year_in`, input, 14: live counter value.
- `mode_time`, output, 1: page select. 0 = time page (hour/minute/second), 1 = date page (day/month/year).
- `select_item`, output, 3: field select. 0 = none. Time page: 1 = hour, 2 = minute, 3 = second. Date page: 1 = day, 2 = month, 3 = year.
- `set_load`, output, 1: one-cycle commit strobe.
- `second_out`, `minute_out`, `hour_out`, `day_out`, outputs, 6 each: shadow values; valid only while `set_load` = 1.
- `month_out`, output, 4: shadow value; valid only while `set_load` = 1.
- `year_out`, output, 14: shadow value; valid only while `set_load` = 1.

Behaviour:
- Reset (`rst_n` = 0 at a clock edge):
  - state RUN.
  - `mode_time`, `select_item`, `set_load` = 0.
  - All shadows = 0.
  - Edge-detect history registers = 0.
  - Timeout counter = 0.
  - Reset mid-edit discards shadows and produces no load.
- Edge detection:
  - A press is an edge where a button is sampled 1 and its registered previous value is 0.
  - The response is registered and visible after that same edge (one-cycle latency from first high sample).
  - Holding a button produces a single press.
- Same-cycle priority: `select` > `mode` > `up`/`down`. `up` and `down` pressed together do nothing.
- FSM state RUN:
  - `mode` toggles `mode_time`.
  - `select` copies all `*_in` into the shadows, sets `select_item` = 1 and moves to EDIT.
  - `up`/`down` are ignored.
- FSM state EDIT:
  - `mode` is ignored, so the page is frozen during edit.
  - `select` with `select_item` < 3 increments `select_item`.
  - `select` with `select_item` = 3 pulses `set_load` for one cycle, sets `select_item` = 0 and returns to RUN.
  - `up`/`down` adjust the selected shadow field ±1 with wrap-around:
    - second, minute: 0..59.
    - hour: 0..23.
    - day: 1..dim.
    - month: 1..12.
    - year: 0..9999.
  - Examples: 59 +1 → 0, 1 −1 → 12, 0 −1 → 9999.
- Days-in-month (dim):
  - 31/30 per month; February is 29 if the shadow year is leap, otherwise 28.
  - Leap rule: (y%4==0 && y%100!=0) || y%400==0. Year 0 is leap.
  - Whenever month or year changes, day is clamped to the new dim in the same update.
- Timeout:
  - Counter clears on any press and on entry to EDIT.
  - On reaching `EDIT_TIMEOUT`−1 in EDIT: return to RUN, `select_item` = 0, no `set_load`.
- Output timing: during `set_load`, `*_out` equal the shadows (day already clamped). Outside `set_load` the `*_out` are don't-care to consumers but must hold the shadows.
- Input range: live inputs outside legal range are captured as-is. The first `up`/`down` on such a field wraps it to the minimum.

Optional Feature:
- Macro: `AUTO_REPEAT_EN`.
- Defined:
  - In EDIT, holding `up` or `down` alone for `HOLD_CYCLES` issues an extra step.
  - Further steps follow every `REPEAT_CYCLES` while the button is held.
  - Release or any other press restarts the hold counter.
  - Each repeat step also clears the timeout counter.
- Undefined: no hold counters exist; one step per press only.

Decomposition:
- Package `clock_pkg`:
  - State enum {RUN, EDIT}.
  - `select_item` codes, named by page.
  - Field limit constants (SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23, MONTH_MAX=12, YEAR_MAX=9999).
  - Field widths (6/4/14).
- Sub-module `days_in_month` (month, year → dim, 5 bits), combinational. Reused by the timekeeping counter block.

Test Plan:
- Reset, then `btn_mode` pulse → `mode_time` 0→1; second pulse → 0; `select_item` stays 0 and `set_load` stays 0.
- RUN time page with inputs 23:59:58; `select` → `select_item`=1; `up` → hour 0; `select`×3 → one-cycle `set_load` with hour=0, minute=59, second=58; then `select_item`=0.
- Date page with day 31, month 1, year 2023; `select`, `select`, `up` (month→2), `select`, `select` → `set_load` with day=28, month=2. Repeat with year 2024 → day=29.
- Year edit: year 9999 `up` → 0. Year 0 `down` → 9999. Year 1900 Feb gives dim 28; year 2000 Feb gives dim 29.
- EDIT with `EDIT_TIMEOUT`=100, no presses → after 100 idle cycles state is RUN, `select_item`=0, `set_load` never asserted. Same sequence with `rst_n`=0 mid-edit → immediate RUN, no load.
- Simultaneous `up`+`down` → no change. `select`+`up` in EDIT → only the field advances. With `AUTO_REPEAT_EN`, `HOLD_CYCLES`=10, `REPEAT_CYCLES`=4, and minute held up for 30 cycles from 10 → minute=16.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types, field codes, limits and step helpers for the clock datapath.
package clock_pkg;

  localparam int unsigned TIME_W  = 6;
  localparam int unsigned MONTH_W = 4;
  localparam int unsigned YEAR_W  = 14;
  localparam int unsigned DIM_W   = 5;

  localparam logic [TIME_W-1:0]  SEC_MAX   = 6'd59;
  localparam logic [TIME_W-1:0]  MIN_MAX   = 6'd59;
  localparam logic [TIME_W-1:0]  HOUR_MAX  = 6'd23;
  localparam logic [MONTH_W-1:0] MONTH_MAX = 4'd12;
  localparam logic [YEAR_W-1:0]  YEAR_MAX  = 14'd9999;

  typedef enum logic {RUN, EDIT} state_e;

  localparam logic [2:0] ITEM_NONE   = 3'd0;
  localparam logic [2:0] ITEM_HOUR   = 3'd1;
  localparam logic [2:0] ITEM_MINUTE = 3'd2;
  localparam logic [2:0] ITEM_SECOND = 3'd3;
  localparam logic [2:0] ITEM_DAY    = 3'd1;
  localparam logic [2:0] ITEM_MONTH  = 3'd2;
  localparam logic [2:0] ITEM_YEAR   = 3'd3;

  function automatic logic is_leap(input logic [YEAR_W-1:0] y);
    return ((y % 14'd4 == 14'd0) && (y % 14'd100 != 14'd0)) || (y % 14'd400 == 14'd0);
  endfunction

  // Out-of-range values snap to the minimum on their first step.
  function automatic logic [YEAR_W-1:0] step_field(input logic [YEAR_W-1:0] v,
                                                   input logic [YEAR_W-1:0] lo,
                                                   input logic [YEAR_W-1:0] hi,
                                                   input logic up);
    if (v < lo || v > hi) return lo;
    if (up) return (v == hi) ? lo : v + 14'd1;
    return (v == lo) ? hi : v - 14'd1;
  endfunction

endpackage

// File: rtl/days_in_month.sv
// Combinational days-in-month lookup; shared with the timekeeping counters.
module days_in_month
  import clock_pkg::*;
(
  input  logic [MONTH_W-1:0] month,
  input  logic [YEAR_W-1:0]  year,
  output logic [DIM_W-1:0]   dim
);

  always_comb begin
    dim = 5'd31;
    case (month)
      4'd2:                     dim = is_leap(year) ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:  dim = 5'd30;
      default:                  dim = 5'd31;
    endcase
  end

endmodule

// File: rtl/time_set_control.sv
// Button-driven page/field selection, shadow editing and commit of time/date.
// Optional press-and-hold auto-repeat is enabled by defining AUTO_REPEAT_EN.
module time_set_control
  import clock_pkg::*;
#(
  parameter int unsigned EDIT_TIMEOUT  = 500_000_000,
  parameter int unsigned HOLD_CYCLES   = 25_000_000,
  parameter int unsigned REPEAT_CYCLES = 5_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_mode,
  input  logic              btn_select,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic [5:0]        second_in,
  input  logic [5:0]        minute_in,
  input  logic [5:0]        hour_in,
  input  logic [5:0]        day_in,
  input  logic [3:0]        month_in,
  input  logic [13:0]       year_in,
  output logic              mode_time,
  output logic [2:0]        select_item,
  output logic              set_load,
  output logic [5:0]        second_out,
  output logic [5:0]        minute_out,
  output logic [5:0]        hour_out,
  output logic [5:0]        day_out,
  output logic [3:0]        month_out,
  output logic [13:0]       year_out
);

  state_e      state_q, state_d;
  logic        mode_time_q, mode_time_d, set_load_q, set_load_d;
  logic [2:0]  item_q, item_d;
  logic [5:0]  sec_q, sec_d, min_q, min_d, hour_q, hour_d, day_q, day_d;
  logic [3:0]  month_q, month_d, month_new;
  logic [13:0] year_q, year_d, year_new;
  logic [31:0] to_cnt_q, to_cnt_d;
  logic        mode_prev_q, sel_prev_q, up_prev_q, dn_prev_q;
  logic        mode_p, sel_p, up_p, dn_p, any_press;
  logic        rep_fire, step_up, step_dn, step_en;
  logic [4:0]  dim_new;

  assign mode_p    = btn_mode   & ~mode_prev_q;
  assign sel_p     = btn_select & ~sel_prev_q;
  assign up_p      = btn_up     & ~up_prev_q;
  assign dn_p      = btn_down   & ~dn_prev_q;
  assign any_press = mode_p | sel_p | up_p | dn_p;

`ifdef AUTO_REPEAT_EN
  logic [31:0] hold_q, hold_d;
  logic        rep_q, rep_d, held;

  assign held = (state_q == EDIT) && (btn_up ^ btn_down) && !btn_select && !btn_mode;

  always_comb begin
    hold_d   = hold_q + 32'd1;
    rep_d    = rep_q;
    rep_fire = 1'b0;
    if (!held || any_press) begin
      hold_d = '0;
      rep_d  = 1'b0;
    end else if ((!rep_q && hold_q == HOLD_CYCLES - 1) ||
                 ( rep_q && hold_q == REPEAT_CYCLES - 1)) begin
      rep_fire = 1'b1;
      hold_d   = '0;
      rep_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q <= '0;
      rep_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      rep_q  <= rep_d;
    end
  end
`else
  assign rep_fire = (HOLD_CYCLES == 0) && (REPEAT_CYCLES == 0) && 1'b0;
`endif

  always_comb begin
    step_up = (up_p & ~btn_down) | (rep_fire & btn_up);
    step_dn = (dn_p & ~btn_up)   | (rep_fire & btn_down);
    step_en = (state_q == EDIT) && !sel_p && !mode_p && (step_up | step_dn);
  end

  // Candidate month/year feed the dim lookup so the day clamp lands in the same update.
  always_comb begin
    month_new = month_q;
    year_new  = year_q;
    if (step_en && mode_time_q) begin
      if (item_q == ITEM_MONTH)
        month_new = 4'(step_field({10'd0, month_q}, 14'd1, {10'd0, MONTH_MAX}, step_up));
      else if (item_q == ITEM_YEAR)
        year_new = step_field(year_q, 14'd0, YEAR_MAX, step_up);
    end
  end

  days_in_month u_dim (
    .month (month_new),
    .year  (year_new),
    .dim   (dim_new)
  );

  always_comb begin
    state_d     = state_q;
    mode_time_d = mode_time_q;
    item_d      = item_q;
    set_load_d  = 1'b0;
    sec_d       = sec_q;
    min_d       = min_q;
    hour_d      = hour_q;
    day_d       = day_q;
    month_d     = month_q;
    year_d      = year_q;
    to_cnt_d    = '0;
    case (state_q)
      RUN: begin
        if (sel_p) begin
          sec_d   = second_in;
          min_d   = minute_in;
          hour_d  = hour_in;
          day_d   = day_in;
          month_d = month_in;
          year_d  = year_in;
          item_d  = ITEM_HOUR;
          state_d = EDIT;
        end else if (mode_p) begin
          mode_time_d = ~mode_time_q;
        end
      end
      EDIT: begin
        if (sel_p) begin
          if (item_q >= ITEM_SECOND) begin
            set_load_d = 1'b1;
            item_d     = ITEM_NONE;
            state_d    = RUN;
          end else begin
            item_d = item_q + 3'd1;
          end
        end else if (step_en) begin
          case ({mode_time_q, item_q})
            4'b0_001: hour_d = 6'(step_field({8'd0, hour_q}, 14'd0, {8'd0, HOUR_MAX}, step_up));
            4'b0_010: min_d  = 6'(step_field({8'd0, min_q},  14'd0, {8'd0, MIN_MAX},  step_up));
            4'b0_011: sec_d  = 6'(step_field({8'd0, sec_q},  14'd0, {8'd0, SEC_MAX},  step_up));
            4'b1_001: day_d  = 6'(step_field({8'd0, day_q},  14'd1, {9'd0, dim_new},  step_up));
            4'b1_010, 4'b1_011: begin
              month_d = month_new;
              year_d  = year_new;
              if (day_q > {1'b0, dim_new}) day_d = {1'b0, dim_new};
            end
            default: ;
          endcase
        end else if (!any_press) begin
          if (to_cnt_q == EDIT_TIMEOUT - 1) begin
            item_d  = ITEM_NONE;
            state_d = RUN;
          end else begin
            to_cnt_d = to_cnt_q + 32'd1;
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RUN;
      mode_time_q <= 1'b0;
      item_q      <= ITEM_NONE;
      set_load_q  <= 1'b0;
      sec_q       <= '0;
      min_q       <= '0;
      hour_q      <= '0;
      day_q       <= '0;
      month_q     <= '0;
      year_q      <= '0;
      to_cnt_q    <= '0;
      mode_prev_q <= 1'b0;
      sel_prev_q  <= 1'b0;
      up_prev_q   <= 1'b0;
      dn_prev_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_time_q <= mode_time_d;
      item_q      <= item_d;
      set_load_q  <= set_load_d;
      sec_q       <= sec_d;
      min_q       <= min_d;
      hour_q      <= hour_d;
      day_q       <= day_d;
      month_q     <= month_d;
      year_q      <= year_d;
      to_cnt_q    <= to_cnt_d;
      mode_prev_q <= btn_mode;
      sel_prev_q  <= btn_select;
      up_prev_q   <= btn_up;
      dn_prev_q   <= btn_down;
    end
  end

  assign mode_time   = mode_time_q;
  assign select_item = item_q;
  assign set_load    = set_load_q;
  assign second_out  = sec_q;
  assign minute_out  = min_q;
  assign hour_out    = hour_q;
  assign day_out     = day_q;
  assign month_out   = month_q;
  assign year_out    = year_q;

endmodule
